// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces one key at a
// time and shifts each accepted key code into an 8-nibble display number.
module keypad_entry #(
  parameter int SCAN_DIV       = 50000,  // cycles each row is driven (>= 4)
  parameter int DEBOUNCE_SCANS = 4       // stable full scans to accept (>= 1)
) (
  input  logic        clk,
  input  logic        rst,        // synchronous, active-low
  output logic [3:0]  row,        // active-low row drive
  input  logic [3:0]  col,        // active-low column sense, asynchronous
  input  logic        clear,      // zeroes number
  output logic [31:0] number,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_COUNT  = CW'(DEBOUNCE_SCANS);

  typedef enum logic {
    S_IDLE,
    S_PRESSED
  } state_e;

  // Physical key position (4*row + col) to hex code.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'hE;  4'd13: code = 4'h0;  4'd14: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]    col_meta_q, col_sync_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_idx_q;
  logic [15:0]   snap_q;
  logic          scan_done_q;

  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] stab_q, stab_d;
  logic [CW-1:0] rel_q, rel_d;
  logic          accept;
  logic [3:0]    accept_code;

  logic [4:0]    hit_cnt;
  logic [3:0]    hit_idx;
  logic          is_none, is_single;

  logic [31:0]   number_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  // Two-flop synchronizer; cleared to the released (all-high) level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    if (!rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Row scanner: dwell per row, snapshot columns on the last dwell cycle,
  // flag the completed scan on the cycle after the row-3 sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_q     <= '0;
      row_idx_q   <= 2'd0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (dwell_q == DWELL_LAST) begin
        dwell_q                       <= '0;
        snap_q[{row_idx_q, 2'b00} +: 4] <= ~col_sync_q;
        row_idx_q                     <= row_idx_q + 2'd1;
        scan_done_q                   <= (row_idx_q == 2'd3);
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  assign row = ~(4'b0001 << row_idx_q);

  // Classify the snapshot: how many keys are down and where the last one is.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign is_none   = (hit_cnt == 5'd0);
  assign is_single = (hit_cnt == 5'd1);

  // Debounce FSM state, candidate key and stability counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      stab_q  <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state logic; only a completed scan can move the debouncer.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    rel_d   = rel_q;
    accept  = 1'b0;
    if (scan_done_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_single) begin
            if (hit_idx == cand_q) begin
              stab_d = stab_q + 1'b1;
            end else begin
              cand_d = hit_idx;
              stab_d = CW'(1);
            end
          end else begin
            stab_d = '0;
          end
          if (stab_d == DEB_COUNT) begin
            state_d = S_PRESSED;
            accept  = 1'b1;
            stab_d  = '0;
            rel_d   = '0;
          end
        end
        S_PRESSED: begin
          rel_d = is_none ? rel_q + 1'b1 : '0;
          if (rel_d == DEB_COUNT) begin
            state_d = S_IDLE;
            stab_d  = '0;
            rel_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign accept_code = key_map(cand_d);

  // Outputs: pulse, held code, and the shifting number with clear priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      number_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= accept_code;
      if (clear) begin
        number_q <= '0;
      end else if (accept) begin
        number_q <= {number_q[27:0], accept_code};
      end
    end
  end

  assign number    = number_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed bench with a keypad matrix model and a scoreboard
// of expected (key_code, number) pairs popped on every key_valid pulse.
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] number;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] pressed = '0;   // bit 4*r+c set = key at row r, col c held

  typedef struct {
    logic [3:0]  code;
    logic [31:0] num;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_num = '0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pulse  = 0;
  int          cyc      = 0;

  keypad_entry #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .clear    (clear),
    .number   (number),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row[r] == 1'b0 && pressed[4*r+c]) col[c] = 1'b0;
  end

  // Timebase: posedges since reset was released.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      exp_t e;
      n_pulse++;
      check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_key_code", {28'd0, key_code}, {28'd0, e.code});
        check("sb_number", number, e.num);
      end
    end
  end

  task automatic press(input int idx, input logic [3:0] code, input int hold);
    exp_num = {exp_num[27:0], code};
    exp_q.push_back('{code: code, num: exp_num});
    pressed = 16'(1) << idx;
    step(hold);
    pressed = '0;
    step(64);
  endtask

  task automatic expect_pulses(input string tag, input int base, input int n);
    check(tag, 32'(n_pulse - base), 32'(n));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int t;

    // Reset values and scan stepping.
    rst = 1'b0;
    step(3);
    check("rst_row", {28'd0, row}, 32'h0000000E);
    check("rst_number", number, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    rst = 1'b1;
    step(3);
    check("row_dwell", {28'd0, row}, 32'h0000000E);
    step(1);
    check("row1", {28'd0, row}, 32'h0000000D);
    step(4);
    check("row2", {28'd0, row}, 32'h0000000B);
    step(4);
    check("row3", {28'd0, row}, 32'h00000007);
    step(4);
    check("row_wrap", {28'd0, row}, 32'h0000000E);

    // Single key at row 1, col 2.
    base = n_pulse;
    press(6, 4'h6, 200);
    expect_pulses("single_pulses", base, 1);
    check("single_code", {28'd0, key_code}, 32'h6);
    check("single_number", number, 32'h00000006);

    // Clear while idle.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    exp_num = '0;
    check("clear_number", number, 32'h0);
    check("clear_keeps_code", {28'd0, key_code}, 32'h6);

    // Sequence and wrap.
    base = n_pulse;
    press(0, 4'h1, 200);
    press(1, 4'h2, 200);
    press(2, 4'h3, 200);
    press(3, 4'hA, 200);
    check("seq_number", number, 32'h0000123A);
    expect_pulses("seq_pulses4", base, 4);
    press(0, 4'h1, 200);
    press(1, 4'h2, 200);
    press(2, 4'h3, 200);
    press(4, 4'h4, 200);
    press(5, 4'h5, 200);
    check("wrap_number", number, 32'h23A12345);
    expect_pulses("wrap_pulses9", base, 9);

    // Bounce shorter than the debounce window.
    base = n_pulse;
    pressed = 16'(1) << 5;
    step(10);
    pressed = '0;
    step(64);
    expect_pulses("bounce_pulses", base, 0);

    // Two keys together, then release one.
    pressed = (16'(1) << 0) | (16'(1) << 5);
    step(100);
    expect_pulses("multi_pulses", base, 0);
    exp_num = {exp_num[27:0], 4'h1};
    exp_q.push_back('{code: 4'h1, num: exp_num});
    pressed = 16'(1) << 0;
    step(200);
    pressed = '0;
    step(64);
    expect_pulses("multi_release_pulses", base, 1);
    check("multi_release_code", {28'd0, key_code}, 32'h1);

    // Clear on the same edge as the key-9 pulse.
    base = n_pulse;
    do step(1); while (cyc % 16 != 1);
    exp_num = '0;
    exp_q.push_back('{code: 4'h9, num: 32'h0});
    pressed = 16'(1) << 10;
    step(31);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("collide_valid", {31'd0, key_valid}, 32'd1);
    check("collide_code", {28'd0, key_code}, 32'h9);
    check("collide_number", number, 32'h0);
    step(168);
    pressed = '0;
    step(64);
    press(13, 4'h0, 200);
    check("after_clear_number", number, 32'h0);
    expect_pulses("collide_pulses", base, 2);

    // Reset in the middle of a debounce with the key still held.
    base = n_pulse;
    pressed = 16'(1) << 15;
    step(20);
    rst = 1'b0;
    step(1);
    check("midrst_valid0", {31'd0, key_valid}, 32'd0);
    step(1);
    check("midrst_valid1", {31'd0, key_valid}, 32'd0);
    check("midrst_number", number, 32'h0);
    rst = 1'b1;
    exp_num = 32'h0000000D;
    exp_q.push_back('{code: 4'hD, num: exp_num});
    t = 0;
    while (t < 80 && n_pulse == base) begin
      step(1);
      t++;
    end
    check("midrst_latency_in_window", 32'(t >= 30 && t <= 52), 32'd1);
    step(100);
    pressed = '0;
    step(64);
    expect_pulses("midrst_pulses", base, 1);
    check("midrst_code", {28'd0, key_code}, 32'hD);
    check("midrst_final_number", number, 32'h0000000D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
